// File: rtl/melody_sequencer_if.sv
// Control and tone-output bundle of the melody sequencer.
// The buttons/switches side drives the requests; the sequencer drives the tone side.
interface melody_sequencer_if;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [27:0] divisor_out;
  logic        tone_en;
  logic [2:0]  note_idx;
  logic        busy;
  logic        done;

  modport master (
    output start, stop, loop_en,
    input  divisor_out, tone_en, note_idx, busy, done
  );

  modport slave (
    input  start, stop, loop_en,
    output divisor_out, tone_en, note_idx, busy, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// Plays a fixed 8-note song as tone-divider settings,
// holding each note for N beats with a silent gap after it.
module melody_sequencer #(
  parameter logic [27:0] TICK_DIV   = 28'd12_500_000,
  parameter logic [27:0] GAP_CYCLES = 28'd2_500_000
) (
  input  logic clock_in,
  input  logic rst_n,
  melody_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [27:0] TICK_LAST = TICK_DIV - 28'd1;
  localparam logic [27:0] GAP_LAST  =
    (GAP_CYCLES == 28'd0) ? 28'd0 : GAP_CYCLES - 28'd1;

  function automatic logic [6:0] f_rom(input logic [2:0] i);
    logic [6:0] v;
    unique case (i)
      3'd0:    v = {4'd1, 3'd1};
      3'd1:    v = {4'd2, 3'd1};
      3'd2:    v = {4'd3, 3'd1};
      3'd3:    v = {4'd0, 3'd1};
      3'd4:    v = {4'd5, 3'd2};
      3'd5:    v = {4'd6, 3'd1};
      3'd6:    v = {4'd7, 3'd1};
      default: v = {4'd8, 3'd3};
    endcase
    return v;
  endfunction

  function automatic logic [27:0] f_div(input logic [3:0] c);
    logic [27:0] d;
    case (c)
      4'd1:    d = 28'd382234;
      4'd2:    d = 28'd340136;
      4'd3:    d = 28'd303030;
      4'd4:    d = 28'd286368;
      4'd5:    d = 28'd255102;
      4'd6:    d = 28'd227273;
      4'd7:    d = 28'd202478;
      4'd8:    d = 28'd191117;
      default: d = 28'd0;
    endcase
    return d;
  endfunction

  state_t      r_state;
  logic [27:0] r_tick;
  logic [27:0] r_gap;
  logic [2:0]  r_beats;
  logic [27:0] r_lat;
  logic [2:0]  r_idx;
  logic [27:0] r_div_out;
  logic        r_tone;
  logic        r_busy;
  logic        r_done;

  state_t      w_nxt;
  logic [27:0] w_tick;
  logic [27:0] w_gap;
  logic [2:0]  w_beats;
  logic [27:0] w_lat;
  logic [2:0]  w_idx;
  logic [6:0]  w_rom;

  assign w_rom = f_rom(r_idx);

  always_comb begin
    w_nxt   = r_state;
    w_tick  = r_tick;
    w_gap   = r_gap;
    w_beats = r_beats;
    w_lat   = r_lat;
    w_idx   = r_idx;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_idx = 3'd0;
          w_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_lat   = f_div(w_rom[6:3]);
        w_beats = (w_rom[2:0] == 3'd0) ? 3'd1 : w_rom[2:0];
        w_tick  = 28'd0;
        w_nxt   = S_PLAY;
      end
      S_PLAY: begin
        if (r_tick >= TICK_LAST) begin
          w_tick  = 28'd0;
          w_beats = r_beats - 3'd1;
          if (r_beats <= 3'd1) begin
            w_gap = 28'd0;
            w_nxt = S_GAP;
          end
        end else begin
          w_tick = r_tick + 28'd1;
        end
      end
      S_GAP: begin
        if (r_gap >= GAP_LAST) begin
          if (r_idx != 3'd7) begin
            w_idx = r_idx + 3'd1;
            w_nxt = S_LOAD;
          end else if (bus.loop_en) begin
            w_idx = 3'd0;
            w_nxt = S_LOAD;
          end else begin
            w_nxt = S_DONE;
          end
        end else begin
          w_gap = r_gap + 28'd1;
        end
      end
      S_DONE: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    // abort wins over everything, including a pending start
    if (bus.stop) begin
      w_nxt   = S_IDLE;
      w_tick  = 28'd0;
      w_gap   = 28'd0;
      w_beats = 3'd0;
      w_lat   = 28'd0;
      w_idx   = 3'd0;
    end
  end

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tick    <= 28'd0;
      r_gap     <= 28'd0;
      r_beats   <= 3'd0;
      r_lat     <= 28'd0;
      r_idx     <= 3'd0;
      r_div_out <= 28'd0;
      r_tone    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_tick    <= w_tick;
      r_gap     <= w_gap;
      r_beats   <= w_beats;
      r_lat     <= w_lat;
      r_idx     <= w_idx;
      r_div_out <= (w_nxt == S_PLAY) ? w_lat : 28'd0;
      r_tone    <= (w_nxt == S_PLAY) && (w_lat != 28'd0);
      r_busy    <= (w_nxt == S_LOAD) || (w_nxt == S_PLAY)
                   || (w_nxt == S_GAP);
      r_done    <= (w_nxt == S_DONE);
    end
  end

  assign bus.divisor_out = r_div_out;
  assign bus.tone_en     = r_tone;
  assign bus.note_idx    = r_idx;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench: a song-position model predicts every cycle,
// a monitor compares the registered outputs after each edge.
module tb_melody_sequencer;

  localparam logic [27:0] TD = 28'd10;
  localparam logic [27:0] GC = 28'd4;

  typedef struct packed {
    logic [27:0] d;
    logic        t;
    logic [2:0]  i;
    logic        b;
    logic        dn;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  melody_sequencer_if bus();

  melody_sequencer #(
    .TICK_DIV(TD),
    .GAP_CYCLES(GC)
  ) dut (
    .clock_in(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int code_t[8] = '{1, 2, 3, 0, 5, 6, 7, 8};
  int beat_t[8] = '{1, 1, 1, 1, 2, 1, 1, 3};

  int n_vec = 0;
  int n_err = 0;
  exp_t q[$];

  int m_mode = 0;
  int m_idx = 0;
  int m_off = 0;

  function automatic logic [27:0] tone_div(input int c);
    case (c)
      1: return 28'd382234;
      2: return 28'd340136;
      3: return 28'd303030;
      4: return 28'd286368;
      5: return 28'd255102;
      6: return 28'd227273;
      7: return 28'd202478;
      8: return 28'd191117;
      default: return 28'd0;
    endcase
  endfunction

  function automatic int play_len(input int i);
    int b;
    b = (beat_t[i] == 0) ? 1 : beat_t[i];
    return b * int'(TD);
  endfunction

  function automatic int note_len(input int i);
    int g;
    g = (GC == 28'd0) ? 1 : int'(GC);
    return 1 + play_len(i) + g;
  endfunction

  task automatic model_step(input bit s, input bit st, input bit lp,
                            output exp_t e);
    if (st) begin
      m_mode = 0;
      m_idx = 0;
    end else begin
      case (m_mode)
        0: if (s) begin
          m_mode = 1;
          m_idx = 0;
          m_off = 0;
        end
        2: m_mode = 0;
        default: begin
          m_off++;
          if (m_off == note_len(m_idx)) begin
            if (m_idx < 7) begin
              m_idx++;
              m_off = 0;
            end else if (lp) begin
              m_idx = 0;
              m_off = 0;
            end else begin
              m_mode = 2;
            end
          end
        end
      endcase
    end
    e = '0;
    e.i = 3'(m_idx);
    if (m_mode == 1) begin
      e.b = 1'b1;
      if (m_off >= 1 && m_off <= play_len(m_idx)) begin
        e.d = tone_div(code_t[m_idx]);
        e.t = (e.d != 28'd0);
      end
    end else if (m_mode == 2) begin
      e.dn = 1'b1;
    end
  endtask

  task automatic cyc(input bit s, input bit st, input bit lp);
    exp_t e;
    @(negedge clk);
    bus.start = s;
    bus.stop = st;
    bus.loop_en = lp;
    model_step(s, st, lp, e);
    q.push_back(e);
  endtask

  function automatic exp_t got();
    exp_t g;
    g.d = bus.divisor_out;
    g.t = bus.tone_en;
    g.i = bus.note_idx;
    g.b = bus.busy;
    g.dn = bus.done;
    return g;
  endfunction

  task automatic check_zero(input string nm);
    exp_t g;
    g = got();
    n_vec++;
    if (g !== exp_t'(0)) begin
      n_err++;
      $display("FAIL %s: got div=%0d tone=%b idx=%0d busy=%b done=%b, need all 0",
               nm, g.d, g.t, g.i, g.b, g.dn);
    end
  endtask

  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        g = got();
        n_vec++;
        if (g !== e) begin
          n_err++;
          $display("FAIL cycle t=%0t: got div=%0d tone=%b idx=%0d busy=%b done=%b, need div=%0d tone=%b idx=%0d busy=%b done=%b",
                   $time, g.d, g.t, g.i, g.b, g.dn, e.d, e.t, e.i, e.b, e.dn);
        end
      end
    end
  end

  initial begin
    int guard;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.loop_en = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;

    repeat (20) cyc(0, 0, 0);

    cyc(1, 0, 0);
    repeat (160) cyc(0, 0, 0);

    cyc(1, 0, 1);
    repeat (200) cyc(0, 0, 1);
    cyc(0, 1, 1);
    repeat (5) cyc(0, 0, 0);

    cyc(1, 0, 0);
    repeat (39) cyc(0, 0, 0);
    cyc(0, 1, 0);
    repeat (5) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (30) cyc(0, 0, 0);
    cyc(0, 1, 0);

    repeat (320) cyc(1, 0, 0);
    cyc(0, 1, 0);

    cyc(1, 0, 0);
    guard = 0;
    while (!(m_mode == 1 && m_off > play_len(m_idx) + 1) && guard < 100) begin
      cyc(0, 0, 0);
      guard++;
    end
    n_vec++;
    if (guard >= 100) begin
      n_err++;
      $display("FAIL gap_reach: got guard=%0d, need < 100", guard);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset_gap");
    q.delete();
    m_mode = 0;
    m_idx = 0;
    m_off = 0;
    repeat (2) @(negedge clk);
    check_zero("reset_hold");
    rst_n = 1'b1;
    repeat (5) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (20) cyc(0, 0, 0);

    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(7) == 0), ($urandom_range(199) == 0),
          1'($urandom_range(1)));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
